// File: rtl/spi_mem_responder.sv
// spi_mem_responder
// SPI mode-0 target that emulates a small serial SRAM. It decodes READ (0x03)
// and WRITE (0x02), each followed by a 24-bit address, against an internal
// byte array. Only the low MEM_AW address bits are used. The SPI pins are
// oversampled: they are synchronised into clk, and all logic runs on clk.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   spi_cs_n          chip select, active low (asynchronous to clk)
//   spi_sclk          SPI clock, idle low, at most clk/8
//   spi_mosi          initiator data, sampled on the sclk rise
//   spi_miso          target data, updated after the sclk fall
//   spi_miso_oe       1 while read data is being driven
//   busy              1 while a transaction is in progress
//   ld_en/ld_addr/ld_data  side-band preload write port
//
// state   | meaning
// IDLE    | waiting for a fresh synchronised cs_n fall
// CMD     | shifting in the 8-bit command
// ADDR_RD | shifting in the 24-bit address of a read
// ADDR_WR | shifting in the 24-bit address of a write
// DATA_RD | driving burst read data on the sclk falls
// DATA_WR | collecting burst write bytes on the sclk rises
// IGNORE  | unknown command; idle until cs_n goes high
module spi_mem_responder #(
   parameter int MEM_AW = 6,
   parameter int SYNC_N = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              busy,
   input  logic              ld_en,
   input  logic [MEM_AW-1:0] ld_addr,
   input  logic [7:0]        ld_data
);
   localparam int DEPTH = 1 << MEM_AW;
   // Holds enough history bits for both the command byte and the retained address bits.
   localparam int SR_W  = (MEM_AW - 1 > 7) ? MEM_AW - 1 : 7;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {IDLE, CMD, ADDR_RD, ADDR_WR, DATA_RD, DATA_WR, IGNORE} state_t;

   state_t state, next_state;

   logic [SYNC_N-1:0] cs_sync, sclk_sync, mosi_sync;
   logic              cs_s, sclk_s, mosi_s;
   logic              cs_q, sclk_q;
   logic              cs_fall, sclk_rise, sclk_fall;

   logic [4:0]        bit_cnt;
   logic [SR_W-1:0]   rx_sr;
   logic [7:0]        tx_sr;
   logic [MEM_AW-1:0] addr_q;
   logic [7:0]        mem [DEPTH];

   logic [7:0]        rx_byte;
   logic [MEM_AW-1:0] rx_addr, rd_addr;
   logic              shift_rx, cnt_inc, cnt_clr, addr_load, tx_load, tx_shift, mem_we;

   // The synchronisers reset to the "cs low" value, and cs_q resets to 0.
   // With cs_n still low after a reset, no fall is ever seen, so no
   // transaction starts until cs_n goes high and then falls again.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_q      <= 1'b0;
         sclk_q    <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_N-2:0], spi_cs_n};
         sclk_sync <= {sclk_sync[SYNC_N-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_N-2:0], spi_mosi};
         cs_q      <= cs_s;
         sclk_q    <= sclk_s;
      end
   end

   assign cs_s      = cs_sync[SYNC_N-1];
   assign sclk_s    = sclk_sync[SYNC_N-1];
   assign mosi_s    = mosi_sync[SYNC_N-1];
   assign cs_fall   = cs_q & ~cs_s;
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;

   assign rx_byte = {rx_sr[6:0], mosi_s};
   assign rx_addr = {rx_sr[MEM_AW-2:0], mosi_s};
   assign rd_addr = addr_load ? rx_addr : addr_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      shift_rx   = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
      addr_load  = 1'b0;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      mem_we     = 1'b0;
      if (cs_s) begin
         next_state = IDLE;
         cnt_clr    = 1'b1;
      end else begin
         unique case (state)
            IDLE: if (cs_fall) begin
               next_state = CMD;
               cnt_clr    = 1'b1;
            end
            CMD: if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == 5'd7) begin
                  cnt_clr = 1'b1;
                  if (rx_byte == CMD_READ)       next_state = ADDR_RD;
                  else if (rx_byte == CMD_WRITE) next_state = ADDR_WR;
                  else                           next_state = IGNORE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ADDR_RD, ADDR_WR: if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == 5'd23) begin
                  cnt_clr   = 1'b1;
                  addr_load = 1'b1;
                  if (state == ADDR_RD) begin
                     tx_load    = 1'b1;
                     next_state = DATA_RD;
                  end else begin
                     next_state = DATA_WR;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            DATA_RD: if (sclk_fall) begin
               tx_shift = 1'b1;
               if (bit_cnt == 5'd7) begin
                  cnt_clr = 1'b1;
                  tx_load = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            DATA_WR: if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == 5'd7) begin
                  cnt_clr = 1'b1;
                  mem_we  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            IGNORE: ;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= '0;
         rx_sr    <= '0;
         tx_sr    <= '0;
         addr_q   <= '0;
         spi_miso <= 1'b0;
      end else begin
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + 5'd1;

         if (shift_rx) rx_sr <= {rx_sr[SR_W-2:0], mosi_s};

         // On the 8th fall of a byte, the last bit goes out and the next byte loads in the same cycle.
         if (tx_load)       tx_sr <= mem[rd_addr];
         else if (tx_shift) tx_sr <= {tx_sr[6:0], 1'b0};

         if (addr_load && !tx_load)  addr_q <= rx_addr;
         else if (tx_load || mem_we) addr_q <= rd_addr + 1'b1;

         if (tx_shift)               spi_miso <= tx_sr[7];
         else if (state != DATA_RD)  spi_miso <= 1'b0;
      end
   end

   // Preload and SPI write are independent ports. The SPI write comes
   // second, so it wins when both target the same address in one cycle.
   always_ff @(posedge clk) begin
      if (ld_en)  mem[ld_addr] <= ld_data;
      if (mem_we) mem[addr_q]  <= rx_byte;
   end

   assign spi_miso_oe = (state == DATA_RD);
   assign busy        = (state != IDLE);
endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: directed scenarios plus randomized bursts,
// checked against a flat byte-array memory model with modulo-depth addressing.
module tb_spi_mem_responder;
   localparam int DEPTH = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_cs_n, spi_sclk, spi_mosi;
   logic       spi_miso, spi_miso_oe, busy;
   logic       ld_en;
   logic [5:0] ld_addr;
   logic [7:0] ld_data;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] model_mem [DEPTH];
   logic [7:0] rx_q [$];
   logic [7:0] wr_q [$];
   logic [7:0] hdr_oe;
   logic [7:0] data_oe;

   spi_mem_responder #(.MEM_AW(6), .SYNC_N(2)) dut (
      .clk(clk), .rst(rst),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got unfinished want finished");
      $fatal(1, "watchdog");
   end

   function automatic int widx(input logic [23:0] addr, input int i);
      return (int'(addr) + i) % DEPTH;
   endfunction

   task automatic preload(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic cs_begin();
      @(negedge clk);
      spi_cs_n = 1'b0;
      #60;
   endtask

   task automatic cs_end();
      #30;
      spi_cs_n = 1'b1;
      #100;
   endtask

   // Shifts n bits MSB-first, sclk half period 60 ns. miso/oe are sampled just
   // before each rise. With ld_last set, a preload pulse spans the final rise.
   task automatic spi_bits(input logic [7:0] tx, input int n, input logic ld_last,
                           input logic [5:0] la, input logic [7:0] ld,
                           output logic [7:0] rx, output logic [7:0] oe);
      rx = '0;
      oe = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = tx[7-i];
         #30;
         rx = {rx[6:0], spi_miso};
         oe = {oe[6:0], spi_miso_oe};
         spi_sclk = 1'b1;
         if (ld_last && i == n - 1) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ld;
            #30;
            ld_en = 1'b0;
            #30;
         end else begin
            #60;
         end
         spi_sclk = 1'b0;
         #30;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
      spi_bits(tx, 8, 1'b0, 6'd0, 8'd0, rx, oe);
   endtask

   task automatic spi_header(input logic [7:0] cmd, input logic [23:0] addr);
      logic [7:0] rx, oe;
      hdr_oe = '0;
      spi_byte(cmd, rx, oe);          hdr_oe |= oe;
      spi_byte(addr[23:16], rx, oe);  hdr_oe |= oe;
      spi_byte(addr[15:8], rx, oe);   hdr_oe |= oe;
      spi_byte(addr[7:0], rx, oe);    hdr_oe |= oe;
   endtask

   task automatic spi_read(input logic [23:0] addr, input int n);
      logic [7:0] rx, oe;
      cs_begin();
      spi_header(8'h03, addr);
      rx_q.delete();
      data_oe = 8'hFF;
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00, rx, oe);
         rx_q.push_back(rx);
         data_oe &= oe;
      end
      cs_end();
   endtask

   task automatic spi_write(input logic [23:0] addr);
      logic [7:0] rx, oe;
      cs_begin();
      spi_header(8'h02, addr);
      data_oe = '0;
      for (int i = 0; i < wr_q.size(); i++) begin
         spi_byte(wr_q[i], rx, oe);
         data_oe |= oe;
         model_mem[widx(addr, i)] = wr_q[i];
      end
      cs_end();
   endtask

   task automatic test_reset();
      rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
      vectors++;
      if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) preload(6'(i), 8'($urandom_range(255)));
   endtask

   task automatic test_write_read();
      wr_q = '{8'hAA, 8'h55};
      spi_write(24'h000010);
      vectors++;
      if ((hdr_oe | data_oe) !== 8'h00) begin miscompares++; $display("FAIL wr_oe: got %h want 00", hdr_oe | data_oe); end
      spi_read(24'h000010, 2);
      vectors++;
      if (hdr_oe !== 8'h00) begin miscompares++; $display("FAIL rd_hdr_oe: got %h want 00", hdr_oe); end
      vectors++;
      if (data_oe !== 8'hFF) begin miscompares++; $display("FAIL rd_data_oe: got %h want ff", data_oe); end
      vectors++;
      if (rx_q[0] !== 8'hAA) begin miscompares++; $display("FAIL rd_byte0: got %h want aa", rx_q[0]); end
      vectors++;
      if (rx_q[1] !== 8'h55) begin miscompares++; $display("FAIL rd_byte1: got %h want 55", rx_q[1]); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_wrap();
      wr_q = '{8'h11, 8'h22};
      spi_write(24'h00003F);
      spi_read(24'h00003F, 2);
      vectors++;
      if (rx_q[0] !== 8'h11) begin miscompares++; $display("FAIL wrap_b0: got %h want 11", rx_q[0]); end
      vectors++;
      if (rx_q[1] !== 8'h22) begin miscompares++; $display("FAIL wrap_b1: got %h want 22", rx_q[1]); end
      spi_read(24'h000000, 1);
      vectors++;
      if (rx_q[0] !== 8'h22) begin miscompares++; $display("FAIL wrap_mem0: got %h want 22", rx_q[0]); end
      spi_read(24'hABCD3F, 2);
      vectors++;
      if (rx_q[0] !== model_mem[63] || rx_q[1] !== model_mem[0]) begin
         miscompares++;
         $display("FAIL wrap_hi_addr: got %h %h want %h %h", rx_q[0], rx_q[1], model_mem[63], model_mem[0]);
      end
   endtask

   task automatic test_unknown_cmd();
      logic [7:0] c;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) c = 8'h9F;
         else begin
            c = 8'($urandom_range(255));
            while (c == 8'h02 || c == 8'h03) c = 8'($urandom_range(255));
         end
         cs_begin();
         spi_header(c, 24'($urandom));
         vectors++;
         if (hdr_oe !== 8'h00) begin miscompares++; $display("FAIL unk_oe cmd %h: got %h want 00", c, hdr_oe); end
         vectors++;
         if (busy !== 1'b1) begin miscompares++; $display("FAIL unk_busy cmd %h: got %b want 1", c, busy); end
         cs_end();
         vectors++;
         if (busy !== 1'b0) begin miscompares++; $display("FAIL unk_busy_end cmd %h: got %b want 0", c, busy); end
      end
      spi_read(24'h000000, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if (rx_q[i] !== model_mem[i]) begin
            miscompares++;
            $display("FAIL unk_mem[%0d]: got %h want %h", i, rx_q[i], model_mem[i]);
         end
      end
   endtask

   task automatic test_abort();
      logic [7:0] rx, oe;
      cs_begin();
      spi_header(8'h02, 24'h000005);
      spi_bits(~model_mem[5], 5, 1'b0, 6'd0, 8'd0, rx, oe);
      cs_end();
      spi_read(24'h000005, 1);
      vectors++;
      if (rx_q[0] !== model_mem[5]) begin miscompares++; $display("FAIL abort_mem5: got %h want %h", rx_q[0], model_mem[5]); end
   endtask

   task automatic test_preload();
      logic [7:0] rx, oe;
      preload(6'd7, 8'hC3);
      spi_read(24'h000007, 1);
      vectors++;
      if (rx_q[0] !== 8'hC3) begin miscompares++; $display("FAIL preload7: got %h want c3", rx_q[0]); end
      cs_begin();
      spi_header(8'h02, 24'h000005);
      spi_bits(8'h5A, 8, 1'b1, 6'd5, 8'hA5, rx, oe);
      cs_end();
      model_mem[5] = 8'h5A;
      spi_read(24'h000005, 1);
      vectors++;
      if (rx_q[0] !== 8'h5A) begin miscompares++; $display("FAIL ld_collide: got %h want 5a", rx_q[0]); end
   endtask

   task automatic test_rst_mid_read();
      logic [7:0] rx, oe;
      logic [23:0] a;
      a = 24'($urandom);
      cs_begin();
      spi_header(8'h03, a);
      spi_byte(8'h00, rx, oe);
      vectors++;
      if (rx !== model_mem[widx(a, 0)]) begin miscompares++; $display("FAIL rst_pre_byte: got %h want %h", rx, model_mem[widx(a, 0)]); end
      spi_bits(8'h00, 4, 1'b0, 6'd0, 8'd0, rx, oe);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      vectors++;
      if ({spi_miso, spi_miso_oe, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_outputs: got miso/oe/busy %b want 000", {spi_miso, spi_miso_oe, busy});
      end
      for (int i = 0; i < 4; i++) begin
         spi_byte(i == 0 ? 8'h03 : 8'h00, rx, oe);
         vectors++;
         if (oe !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ignored byte %0d: got oe %h busy %b want 00 0", i, oe, busy);
         end
      end
      cs_end();
      spi_read(a, 3);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (rx_q[i] !== model_mem[widx(a, i)]) begin
            miscompares++;
            $display("FAIL rst_after_read %0d: got %h want %h", i, rx_q[i], model_mem[widx(a, i)]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] a;
      int n;
      for (int k = 0; k < 14; k++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 6);
         if (k % 2 == 0) begin
            wr_q.delete();
            for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom_range(255)));
            spi_write(a);
         end else begin
            spi_read(a, n);
            for (int i = 0; i < n; i++) begin
               vectors++;
               if (rx_q[i] !== model_mem[widx(a, i)]) begin
                  miscompares++;
                  $display("FAIL b2b_read k%0d byte %0d: got %h want %h", k, i, rx_q[i], model_mem[widx(a, i)]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_unknown_cmd();
      test_abort();
      test_preload();
      test_rst_mid_read();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
